// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared LSU queue entry types, sizes and load-execute FSM states
package lsu_pkg;

  localparam int LSU_XLEN          = 32;
  localparam int LSU_ROB_TAG_WIDTH = 32;
  localparam int LSU_LDQ_SIZE      = 16;
  localparam int LSU_STQ_SIZE      = 16;

  typedef struct packed {
    logic                         valid;
    logic [LSU_XLEN-1:0]          address;
    logic                         address_valid;
    logic                         executed;
    logic [LSU_ROB_TAG_WIDTH-1:0] rob_tag;
    logic [LSU_STQ_SIZE-1:0]      store_mask;
  } load_queue_entry;

  typedef struct packed {
    logic                valid;
    logic [LSU_XLEN-1:0] address;
    logic                address_valid;
    logic [LSU_XLEN-1:0] data;
    logic                data_valid;
  } store_queue_entry;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MEM_REQ,
    MEM_WAIT,
    BROADCAST
  } load_exec_state_t;

  // Word granularity compare: byte offset bits are ignored.
  function automatic logic same_word(input logic [LSU_XLEN-1:0] a, input logic [LSU_XLEN-1:0] b);
    return ((a ^ b) >> 2) == '0;
  endfunction

endpackage

// File: rtl/circular_priority_select.sv
// rtl/circular_priority_select.sv - first set request bit from a start index, scanning forward (DIR=0) or backward (DIR=1)
module circular_priority_select #(
  parameter int N   = 16,
  parameter bit DIR = 1'b0,
  localparam int W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  function automatic logic [W-1:0] step(input logic [W-1:0] s, input int i);
    return DIR ? (s - W'(i)) : (s + W'(i));
  endfunction

  // Scan from farthest to nearest so the nearest set bit is the final write.
  always_comb begin
    found = 1'b0;
    idx   = start;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[step(start, i)]) begin
        found = 1'b1;
        idx   = step(start, i);
      end
    end
  end

endmodule

// File: rtl/load_execute_unit.sv
// rtl/load_execute_unit.sv - executes the oldest ready load via STQ forwarding or a memory read, then broadcasts on the CDB
// Store-to-load forwarding is built only when LSU_STORE_FORWARD_EN is defined.
module load_execute_unit
  import lsu_pkg::*;
#(
  parameter int XLEN          = LSU_XLEN,
  parameter int ROB_TAG_WIDTH = LSU_ROB_TAG_WIDTH,
  parameter int LDQ_SIZE      = LSU_LDQ_SIZE,
  parameter int STQ_SIZE      = LSU_STQ_SIZE
) (
  input  logic                         clk,
  input  logic                         reset,
  input  load_queue_entry              load_queue_entries [LDQ_SIZE],
  input  logic [$clog2(LDQ_SIZE)-1:0]  ldq_head,
  input  store_queue_entry             store_queue_entries [STQ_SIZE],
  input  logic [$clog2(STQ_SIZE)-1:0]  stq_tail,
  input  logic                         flush,
  output logic                         load_executed,
  output logic [ROB_TAG_WIDTH-1:0]     load_executed_rob_tag,
  output logic                         load_succeeded,
  output logic [ROB_TAG_WIDTH-1:0]     load_succeeded_rob_tag,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [XLEN-1:0]              mem_req_addr,
  input  logic                         mem_resp_valid,
  input  logic [XLEN-1:0]              mem_resp_data,
  output logic                         cdb_valid,
  input  logic                         cdb_grant,
  output logic [ROB_TAG_WIDTH-1:0]     cdb_rob_tag,
  output logic [XLEN-1:0]              cdb_data
);

  localparam int LW = $clog2(LDQ_SIZE);
  localparam int SW = $clog2(STQ_SIZE);

  load_exec_state_t         state, state_n;
  logic [XLEN-1:0]          ld_addr, ld_addr_n;
  logic [XLEN-1:0]          ld_data, ld_data_n;
  logic [ROB_TAG_WIDTH-1:0] ld_tag, ld_tag_n;
  logic [STQ_SIZE-1:0]      ld_mask, ld_mask_n;
  logic                     drop, drop_n;
  logic                     exec_q, exec_n;
  logic                     succ_q, succ_n;

  logic [LDQ_SIZE-1:0]      ld_ready;
  logic                     ld_found;
  logic [LW-1:0]            ld_idx;
  logic [STQ_SIZE-1:0]      st_match;
  logic                     st_found;
  logic [SW-1:0]            st_idx;
  logic [SW-1:0]            stq_youngest;

  always_comb begin
    ld_ready = '0;
    for (int i = 0; i < LDQ_SIZE; i++) begin
      ld_ready[i] = load_queue_entries[i].valid & load_queue_entries[i].address_valid &
                    ~load_queue_entries[i].executed;
    end
  end

  circular_priority_select #(.N(LDQ_SIZE), .DIR(1'b0)) u_ldq_pick (
    .req   (ld_ready),
    .start (ldq_head),
    .found (ld_found),
    .idx   (ld_idx)
  );

  // Older stores without a resolved address are deliberately not matched.
  always_comb begin
    st_match = '0;
    for (int j = 0; j < STQ_SIZE; j++) begin
      st_match[j] = store_queue_entries[j].valid & ld_mask[j] & store_queue_entries[j].address_valid &
                    same_word(store_queue_entries[j].address, ld_addr);
    end
  end

  assign stq_youngest = stq_tail - SW'(1);

  circular_priority_select #(.N(STQ_SIZE), .DIR(1'b1)) u_stq_pick (
    .req   (st_match),
    .start (stq_youngest),
    .found (st_found),
    .idx   (st_idx)
  );

`ifndef LSU_STORE_FORWARD_EN
  logic unused_fwd;
  assign unused_fwd = ^{store_queue_entries[st_idx].data, store_queue_entries[st_idx].data_valid};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ld_addr <= '0;
      ld_data <= '0;
      ld_tag  <= '0;
      ld_mask <= '0;
      drop    <= 1'b0;
      exec_q  <= 1'b0;
      succ_q  <= 1'b0;
    end else begin
      state   <= state_n;
      ld_addr <= ld_addr_n;
      ld_data <= ld_data_n;
      ld_tag  <= ld_tag_n;
      ld_mask <= ld_mask_n;
      drop    <= drop_n;
      exec_q  <= exec_n;
      succ_q  <= succ_n;
    end
  end

  always_comb begin
    state_n   = state;
    ld_addr_n = ld_addr;
    ld_data_n = ld_data;
    ld_tag_n  = ld_tag;
    ld_mask_n = ld_mask;
    drop_n    = drop;
    exec_n    = 1'b0;
    succ_n    = 1'b0;
    case (state)
      IDLE: begin
        drop_n = 1'b0;
        if (ld_found && !flush) begin
          ld_addr_n = load_queue_entries[ld_idx].address;
          ld_tag_n  = load_queue_entries[ld_idx].rob_tag;
          ld_mask_n = load_queue_entries[ld_idx].store_mask;
          state_n   = CHECK;
        end
      end
      CHECK: begin
        if (flush) begin
          state_n = IDLE;
        end else if (st_found) begin
`ifdef LSU_STORE_FORWARD_EN
          if (store_queue_entries[st_idx].data_valid) begin
            ld_data_n = store_queue_entries[st_idx].data;
            exec_n    = 1'b1;
            state_n   = BROADCAST;
          end else begin
            state_n = IDLE;
          end
`else
          state_n = IDLE;
`endif
        end else begin
          exec_n  = 1'b1;
          state_n = MEM_REQ;
        end
      end
      // The request stays up under flush; only its result is discarded.
      MEM_REQ: begin
        if (flush) drop_n = 1'b1;
        if (mem_req_ready) state_n = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (flush) drop_n = 1'b1;
        if (mem_resp_valid) begin
          ld_data_n = mem_resp_data;
          state_n   = (drop || flush) ? IDLE : BROADCAST;
        end
      end
      BROADCAST: begin
        if (flush) begin
          state_n = IDLE;
        end else if (cdb_grant) begin
          succ_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign load_executed          = exec_q;
  assign load_executed_rob_tag  = ld_tag;
  assign load_succeeded         = succ_q;
  assign load_succeeded_rob_tag = ld_tag;
  assign mem_req_valid          = (state == MEM_REQ);
  assign mem_req_addr           = {ld_addr[XLEN-1:2], 2'b00};
  assign cdb_valid              = (state == BROADCAST);
  assign cdb_rob_tag            = ld_tag;
  assign cdb_data               = ld_data;

endmodule
